// File: rtl/ahb_slave_fifo_periph.sv
// AHB-Lite subordinate wrapping a word FIFO with STATUS, WAITCFG and CTRL registers.
// Data-phase FSM inserts programmable wait states or a two-cycle ERROR response.
module ahb_slave_fifo_periph #(
   parameter int DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA,
   output logic        dma_req
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_WAIT   = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

   state_t        state_reg;
   logic          pend_reg;
   logic [1:0]    pend_addr_reg;
   logic          pend_write_reg;
   logic [2:0]    wait_cnt_reg;
   logic [2:0]    waitcfg_reg;
   logic [2:0]    waitcfg_next;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW-1:0] wr_ptr_reg;
   logic [AW:0]   count_reg;
   logic [AW:0]   count_next;
   logic          hreadyout_reg;
   logic          hresp_reg;
   logic [31:0]   mem [DEPTH];

   logic        fin_ok;
   logic        do_push;
   logic        do_pop;
   logic        do_cfg;
   logic        do_flush;
   logic        accept;
   logic        xfer_err;
   logic [1:0]  addr_sel;
   logic [31:0] status_word;
   logic [31:0] rdata_mux;
   logic        unused_bits;

   assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0]};

   // A pending OKAY transfer is in its last data-phase cycle once the FSM is back in IDLE.
   assign fin_ok   = (state_reg == ST_IDLE) && pend_reg;
   assign do_push  = fin_ok &&  pend_write_reg && (pend_addr_reg == REG_DATA);
   assign do_pop   = fin_ok && !pend_write_reg && (pend_addr_reg == REG_DATA);
   assign do_cfg   = fin_ok &&  pend_write_reg && (pend_addr_reg == REG_WAIT);
   assign do_flush = fin_ok &&  pend_write_reg && (pend_addr_reg == REG_CTRL) && HWDATA[0];

   always_comb begin
      count_next = count_reg;
      if (do_flush)
         count_next = '0;
      else if (do_push)
         count_next = count_reg + 1'b1;
      else if (do_pop)
         count_next = count_reg - 1'b1;
   end

   assign waitcfg_next = do_cfg ? HWDATA[2:0] : waitcfg_reg;

   // Full/empty are judged after any commit landing on the same edge, so a
   // pipelined follow-on transfer never overflows or underflows the FIFO.
   assign addr_sel = HADDR[3:2];
   assign accept   = HSEL && HREADY && HTRANS[1] && hreadyout_reg;
   assign xfer_err = (HSIZE != 3'b010) ||
                     (HWRITE && (addr_sel == REG_STATUS)) ||
                     (HWRITE && (addr_sel == REG_DATA) && (count_next == FULL_CNT)) ||
                     (!HWRITE && (addr_sel == REG_DATA) && (count_next == '0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         pend_reg       <= 1'b0;
         pend_addr_reg  <= '0;
         pend_write_reg <= 1'b0;
         wait_cnt_reg   <= '0;
         hreadyout_reg  <= 1'b1;
         hresp_reg      <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE, ST_ERR2: begin
               hresp_reg <= 1'b0;
               pend_reg  <= 1'b0;
               state_reg <= ST_IDLE;
               hreadyout_reg <= 1'b1;
               if (accept) begin
                  pend_addr_reg  <= addr_sel;
                  pend_write_reg <= HWRITE;
                  if (xfer_err) begin
                     state_reg     <= ST_ERR1;
                     hreadyout_reg <= 1'b0;
                     hresp_reg     <= 1'b1;
                  end else begin
                     pend_reg <= 1'b1;
                     if (waitcfg_next != 3'd0) begin
                        state_reg     <= ST_WAIT;
                        wait_cnt_reg  <= waitcfg_next;
                        hreadyout_reg <= 1'b0;
                     end
                  end
               end
            end
            ST_WAIT: begin
               if (wait_cnt_reg <= 3'd1) begin
                  state_reg     <= ST_IDLE;
                  hreadyout_reg <= 1'b1;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg - 3'd1;
               end
            end
            ST_ERR1: begin
               state_reg     <= ST_ERR2;
               hreadyout_reg <= 1'b1;
               hresp_reg     <= 1'b1;
            end
            default: begin
               state_reg     <= ST_IDLE;
               hreadyout_reg <= 1'b1;
               hresp_reg     <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_reg  <= '0;
         wr_ptr_reg  <= '0;
         count_reg   <= '0;
         waitcfg_reg <= '0;
      end else begin
         waitcfg_reg <= waitcfg_next;
         count_reg   <= count_next;
         if (do_flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
         end else begin
            if (do_push)
               wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)
               rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
      end
   end

   // Storage is not cleared by reset or flush; only the pointers move.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr_reg] <= HWDATA;
   end

   always_comb begin
      status_word      = '0;
      status_word[4:0] = 5'(count_reg);
      status_word[5]   = (count_reg == '0);
      status_word[6]   = (count_reg == FULL_CNT);
   end

   always_comb begin
      rdata_mux = '0;
      if (fin_ok && !pend_write_reg) begin
         case (pend_addr_reg)
            REG_DATA:   rdata_mux = mem[rd_ptr_reg];
            REG_STATUS: rdata_mux = status_word;
            REG_WAIT:   rdata_mux = {29'd0, waitcfg_reg};
            default:    rdata_mux = '0;
         endcase
      end
   end

   assign HRDATA    = rdata_mux;
   assign HREADYOUT = hreadyout_reg;
   assign HRESP     = hresp_reg;
   assign dma_req   = (count_reg != '0);

endmodule

// File: doc/ahb_slave_fifo_periph.md
AHB_SLAVE_FIFO_PERIPH -- requirements
Module: ahb_slave_fifo_periph

Interface
REQ-001 SHALL have one clock and asynchronous, active-high reset: clk (in, 1, rising-edge clock); rst (in, 1, asynchronous active-high reset).
REQ-002 SHALL have AHB-Lite subordinate inputs:
  - HSEL (in, 1, slave select)
  - HADDR (in, 32, address)
  - HTRANS (in, 2, transfer type)
  - HWRITE (in, 1, write = 1)
  - HSIZE (in, 3, transfer size)
  - HWDATA (in, 32, write data)
  - HREADY (in, 1, bus-ready from interconnect)
REQ-003 SHALL have AHB-Lite subordinate outputs:
  - HREADYOUT (out, 1, transfer done)
  - HRESP (out, 1, 0 = OKAY, 1 = ERROR)
  - HRDATA (out, 32, read data)
REQ-004 SHALL have dma_req (out, 1): high while the FIFO holds at least one word.
REQ-005 SHALL have one parameter, DEPTH (default 16, power of two): number of FIFO entries.

Function
REQ-006 SHALL accept an address phase when HSEL & HREADY & HTRANS[1] are all 1 on a rising edge; it captures HADDR[3:2], HWRITE and HSIZE.
REQ-007 SHALL treat an IDLE or BUSY transfer, or HSEL=0, as no transfer: response is zero-wait OKAY with no state change.
REQ-008 SHALL decode the following registers; HADDR[31:4] and HADDR[1:0] are ignored.
  - 0x0 DATA: a write pushes HWDATA; a read pops the head word.
  - 0x4 STATUS, read-only: [4:0] count, [5] empty, [6] full, [31:7] = 0.
  - 0x8 WAITCFG: read/write, bits [2:0]; upper bits read 0.
  - 0xC CTRL: a write with bit0 = 1 flushes the FIFO; reads return 0.
REQ-009 SHALL run a data-phase FSM with states IDLE, WAIT, ERR1, ERR2.
REQ-010 SHALL leave IDLE on an accepted OKAY transfer as follows:
  - WAITCFG = 0: completes in the next cycle with HREADYOUT = 1.
  - WAITCFG = N > 0: enters WAIT with HREADYOUT = 0 for exactly N cycles, then HREADYOUT = 1 for one cycle.
REQ-011 SHALL classify a transfer as error when any of the following holds:
  - HSIZE != 3'b010
  - write to STATUS
  - DATA write while full
  - DATA read while empty
  Full and empty are evaluated at the address-phase edge.
REQ-012 SHALL respond to an error transfer with a two-cycle ERROR response and no wait states:
  - ERR1: HREADYOUT = 0, HRESP = 1.
  - ERR2: HREADYOUT = 1, HRESP = 1.
  - No register or FIFO change occurs.
REQ-013 SHALL sample HWDATA and commit the write in the final data-phase cycle (HREADYOUT = 1, HRESP = 0).
REQ-014 SHALL drive HRDATA only in the final cycle of a successful read; HRDATA is 0 at all other times.
REQ-015 SHALL give a STATUS read the count as it stands at that final cycle.
REQ-016 SHALL accept a new address phase during the final data-phase cycle (pipelined back-to-back transfers), with no idle cycle inserted.
REQ-017 SHALL implement the FIFO as follows:
  - Read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH.
  - A count of log2(DEPTH)+1 bits.
  - Full when count = DEPTH; empty when count = 0.
REQ-018 SHALL give a flush priority over nothing else pending: pointers and count clear at the commit edge, and FIFO contents are not cleared.
REQ-019 SHALL update dma_req combinationally from the registered count.

Reset
REQ-020 SHALL, while rst = 1, hold:
  - FSM in IDLE
  - HREADYOUT = 1, HRESP = 0, HRDATA = 0
  - count = 0, pointers = 0
  - WAITCFG = 0
  - dma_req = 0
REQ-021 SHALL abort an in-progress transfer when rst asserts mid-transfer; no partial commit occurs.

Verification
REQ-022 Zero-wait write then read:
  - Write 0xDEADBEEF to 0x0 → OKAY, dma_req = 1.
  - Read 0x0 → HRDATA = 0xDEADBEEF; dma_req then 0.
REQ-023 Wait states:
  - Write 3 to 0x8.
  - Read 0x4 → HREADYOUT low for exactly 3 cycles, then HRDATA = 0x20.
REQ-024 Fill and overflow:
  - 16 writes of 0..15 → STATUS = 0x50.
  - 17th write → ERR1/ERR2 sequence; count stays 16.
  - 16 reads return 0..15 in order.
REQ-025 Errors:
  - Read 0x0 when empty → two-cycle ERROR.
  - HSIZE = 3'b000 write to 0x8 → ERROR; WAITCFG unchanged.
  - Write to 0x4 → ERROR.
REQ-026 Wrap and flush:
  - 10 writes, 10 reads, then 12 writes → count 12, data returned in order.
  - Write 1 to 0xC → STATUS = 0x20.
REQ-027 Reset mid-transfer:
  - Assert rst during the WAIT of a DATA write with WAITCFG = 5.
  - Required: HREADYOUT = 1, count = 0, and a subsequent DATA read returns ERROR.
